mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_pkg.sv | 16 +
 rtl/mem_bus_arbiter_timeout_ctr.sv | 22 ++
 rtl/mem_bus_arbiter.sv | 83 ++++++++
 tb/tb_mem_bus_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared state/grant encodings and timeout default for the bus arbiter.
package mem_bus_arbiter_pkg;
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;
  localparam int TIMEOUT_DEFAULT  = 15;
  // State codes equal the one-hot grant vector so o_gnt comes straight off the state flops.
  typedef enum logic [1:0] {
    IDLE = GNT_NONE,
    GNT0 = GNT_M0,
    GNT1 = GNT_M1
  } state_t;
  function automatic state_t tie_winner(input logic last_grant);
    return last_grant ? GNT0 : GNT1;
  endfunction
endpackage

// File: rtl/mem_bus_arbiter_timeout_ctr.sv
// bus_timeout_ctr: saturating wait counter that flags when the slave has not acked in TIMEOUT cycles.
module bus_timeout_ctr
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (run && cnt != LIMIT) cnt <= cnt + 1'b1;
  end
  assign expired = cnt == LIMIT;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin two-master arbiter onto one shared bus slave, with ack timeout.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_sel,
  output logic                    m0_ack,
  output logic                    m0_err,
  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_sel,
  output logic                    m1_ack,
  output logic                    m1_err,
  output logic [DATA_WIDTH-1:0]   m_rdata,
  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [ADDR_WIDTH-1:0]   s_addr,
  output logic [DATA_WIDTH-1:0]   s_wdata,
  output logic [DATA_WIDTH/8-1:0] s_sel,
  input  logic                    s_ack,
  input  logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              o_gnt
);
  state_t state, state_nx;
  logic last_grant, gnt0, gnt1, req_stb, expired, timeout;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (m0_cyc && m1_cyc) ? tie_winner(last_grant) : m0_cyc ? GNT0 : m1_cyc ? GNT1 : IDLE;
      GNT0:    state_nx = m0_cyc ? GNT0 : m1_cyc ? GNT1 : IDLE;
      GNT1:    state_nx = m1_cyc ? GNT1 : m0_cyc ? GNT0 : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_nx;
      if (state_nx == GNT0) last_grant <= 1'b0;
      else if (state_nx == GNT1) last_grant <= 1'b1;
    end
  end
  assign gnt0  = state == GNT0;
  assign gnt1  = state == GNT1;
  assign o_gnt = state;
  assign s_cyc   = gnt0 ? m0_cyc   : gnt1 ? m1_cyc   : 1'b0;
  assign req_stb = gnt0 ? m0_stb   : gnt1 ? m1_stb   : 1'b0;
  assign s_we    = gnt0 ? m0_we    : gnt1 ? m1_we    : 1'b0;
  assign s_addr  = gnt0 ? m0_addr  : gnt1 ? m1_addr  : '0;
  assign s_wdata = gnt0 ? m0_wdata : gnt1 ? m1_wdata : '0;
  assign s_sel   = gnt0 ? m0_sel   : gnt1 ? m1_sel   : '0;
  // A late ack in the expiry cycle still completes the transfer, so it suppresses the error.
  assign timeout = expired & ~s_ack & (gnt0 | gnt1);
  assign s_stb   = req_stb & ~timeout;
  assign m0_ack  = s_ack & gnt0;
  assign m1_ack  = s_ack & gnt1;
  assign m0_err  = timeout & gnt0;
  assign m1_err  = timeout & gnt1;
  assign m_rdata = s_rdata;
  bus_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (s_cyc & req_stb & ~s_ack),
    .clr     (s_ack | timeout | (state == IDLE) | (state_nx != state)),
    .expired (expired)
  );
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed stimulus with a response scoreboard for mem_bus_arbiter.
module tb_mem_bus_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0, s_rdata = '0;
  logic [3:0] m0_sel = '0, m1_sel = '0;
  logic s_ack = 0;
  logic m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb, s_we;
  logic [31:0] m_rdata, s_addr, s_wdata;
  logic [3:0] s_sel;
  logic [1:0] o_gnt;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic a0, a1, e0, e1;
    logic [31:0] rd;
    logic stb;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e, mon_a;

  mem_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_err(m1_err),
    .m_rdata(m_rdata), .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_sel(s_sel), .s_ack(s_ack), .s_rdata(s_rdata), .o_gnt(o_gnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", n, act, exp);
    end
  endtask

  // Monitor: every ack/err the DUT raises must match the next queued expectation.
  always @(negedge clk) begin
    if (m0_ack | m1_ack | m0_err | m1_err) begin
      checks++;
      mon_a = '{m0_ack, m1_ack, m0_err, m1_err, m_rdata, s_stb};
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got ack=%b%b err=%b%b, required no response",
                 m0_ack, m1_ack, m0_err, m1_err);
      end else begin
        mon_e = sb.pop_front();
        if (mon_a !== mon_e) begin
          errors++;
          $display("FAIL resp: got ack=%b%b err=%b%b rdata=%h stb=%b, required ack=%b%b err=%b%b rdata=%h stb=%b",
                   mon_a.a0, mon_a.a1, mon_a.e0, mon_a.e1, mon_a.rd, mon_a.stb,
                   mon_e.a0, mon_e.a1, mon_e.e0, mon_e.e1, mon_e.rd, mon_e.stb);
        end
      end
    end
  end

  initial begin
    #12;
    chk("rst_gnt", o_gnt, 2'b00);
    chk("rst_s_cyc", s_cyc, 0);
    chk("rst_s_stb", s_stb, 0);
    chk("rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 4'b0000);
    step();
    rst_n = 1'b1;
    step();
    chk("idle_gnt", o_gnt, 2'b00);
    // Simultaneous request after reset: m0 wins the first tie.
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h100;
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h200;
    #1 chk("pre_edge_gnt", o_gnt, 2'b00);
    step();
    chk("tie_gnt_m0", o_gnt, 2'b01);
    chk("s_addr_m0", s_addr, 32'h100);
    chk("s_stb_m0", s_stb, 1);
    step();
    step();
    sb.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1});
    s_rdata = 32'hDEADBEEF; s_ack = 1;
    #1 chk("m1_ack_blocked", m1_ack, 0);
    chk("rdata_bcast", m_rdata, 32'hDEADBEEF);
    step();
    s_ack = 0;
    // Handover without idle bubble.
    m0_cyc = 0; m0_stb = 0;
    #1 chk("drop_s_cyc", s_cyc, 0);
    chk("drop_gnt_held", o_gnt, 2'b01);
    step();
    chk("handover_gnt", o_gnt, 2'b10);
    chk("s_addr_m1", s_addr, 32'h200);
    // Timeout: stb high in cycles 1..15, error in cycle 16.
    sb.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0});
    for (int i = 1; i <= 15; i++) begin
      if (i == 1 || i == 15) chk("stb_waiting", s_stb, 1);
      step();
    end
    chk("timeout_stb_low", s_stb, 0);
    chk("timeout_m0_err", m0_err, 0);
    chk("timeout_gnt_kept", o_gnt, 2'b10);
    step();
    chk("post_timeout_stb", s_stb, 1);
    chk("post_timeout_err", m1_err, 0);
    for (int i = 0; i < 15; i++) step();
    // Counter sits at TIMEOUT here; a coincident ack must win.
    sb.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 32'h12345678, 1'b1});
    s_rdata = 32'h12345678; s_ack = 1;
    #1 chk("ack_wins_err", m1_err, 0);
    chk("ack_wins_ack", m1_ack, 1);
    step();
    s_ack = 0;
    m1_cyc = 0; m1_stb = 0;
    step();
    chk("release_idle", o_gnt, 2'b00);
    m0_cyc = 1; m1_cyc = 1;
    step();
    chk("rr_tie_m0", o_gnt, 2'b01);
    m0_cyc = 0; m1_cyc = 0;
    step();
    chk("idle_again", o_gnt, 2'b00);
    m0_cyc = 1; m1_cyc = 1;
    step();
    chk("rr_tie_m1", o_gnt, 2'b10);
    m0_cyc = 0; m1_stb = 1;
    step();
    chk("m1_held", o_gnt, 2'b10);
    chk("m1_s_cyc", s_cyc, 1);
    // Asynchronous reset mid-transfer.
    #1 rst_n = 0;
    #1 chk("async_rst_gnt", o_gnt, 2'b00);
    chk("async_rst_s_cyc", s_cyc, 0);
    s_ack = 1;
    #1 chk("rst_no_ack", {m0_ack, m1_ack, m0_err, m1_err}, 4'b0000);
    step();
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    step();
    rst_n = 1;
    step();
    step();
    chk("final_idle", o_gnt, 2'b00);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
